// File: rtl/lap_recorder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lap_recorder_pkg : shared stopwatch constants, state and entry types |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package lap_recorder_pkg;

    localparam int DEPTH_DEF = 8;
    localparam int IDX_W_DEF = $clog2(DEPTH_DEF);
    localparam int CNT_W_DEF = IDX_W_DEF + 1;

    typedef enum logic [0:0] {
        ST_LIVE   = 1'b0,
        ST_RECALL = 1'b1
    } state_e;

    typedef struct packed {
        logic [7:0] hours;
        logic [7:0] minutes;
        logic [7:0] seconds;
        logic [7:0] centisec;
    } snap_t;

    // Step through the valid entries 0..cnt-1, wrapping back to entry 0.
    function automatic int unsigned wrap_next(input int unsigned idx, input int unsigned cnt);
        return ((idx + 1) < cnt) ? (idx + 1) : 0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/edge_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | edge_detect : one-cycle pulse on a rising level                      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic level_i,
    output logic pulse_o
);

    logic prev_q;
    logic armed_q;

    // The first cycle after reset only samples, so a level already high
    // when reset releases never produces an event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= level_i;
            armed_q <= 1'b1;
        end
    end

    assign pulse_o = armed_q & level_i & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/lap_recorder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lap_recorder : lap snapshot storage with live/recall display mux     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lap_recorder
    import lap_recorder_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEF,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int CNT_W = IDX_W + 1
) (
    input  logic             clk_100Hz,
    input  logic             rst,
    input  logic [7:0]       hours,
    input  logic [7:0]       minutes,
    input  logic [7:0]       seconds,
    input  logic [7:0]       centisec,
    input  logic             lap,
    input  logic             recall,
    input  logic             next,
    input  logic             clear,
    output logic [7:0]       disp_hours,
    output logic [7:0]       disp_minutes,
    output logic [7:0]       disp_seconds,
    output logic [7:0]       disp_centisec,
    output logic [CNT_W-1:0] lap_count,
    output logic [IDX_W-1:0] recall_idx,
    output logic             full,
    output logic             recall_active
);

    logic lap_ev;
    logic next_ev;
    logic clear_ev;

    edge_detect u_lap_ed (
        .clk     (clk_100Hz),
        .rst     (rst),
        .level_i (lap),
        .pulse_o (lap_ev)
    );

    edge_detect u_next_ed (
        .clk     (clk_100Hz),
        .rst     (rst),
        .level_i (next),
        .pulse_o (next_ev)
    );

    edge_detect u_clear_ed (
        .clk     (clk_100Hz),
        .rst     (rst),
        .level_i (clear),
        .pulse_o (clear_ev)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    snap_t            disp_q, disp_d;
    snap_t            mem_q [DEPTH];

    snap_t            live_snap;
    logic             full_w;
    logic             lap_accept;

    assign live_snap  = '{hours: hours, minutes: minutes, seconds: seconds, centisec: centisec};
    assign full_w     = (count_q == CNT_W'(DEPTH));
    assign lap_accept = lap_ev & ~clear_ev & ~full_w;

    always_ff @(posedge clk_100Hz or posedge rst) begin
        if (rst) begin
            state_q <= ST_LIVE;
            count_q <= '0;
            idx_q   <= '0;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            disp_q  <= disp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        disp_d  = '0;

        state_d = recall ? ST_RECALL : ST_LIVE;

        if (clear_ev) begin
            count_d = '0;
        end else if (lap_accept) begin
            count_d = count_q + CNT_W'(1);
        end

        // The wrap point uses count_q, i.e. the count before any lap this cycle.
        if (clear_ev) begin
            idx_d = '0;
        end else if ((state_q == ST_LIVE) && recall) begin
            idx_d = '0;
        end else if ((state_q == ST_RECALL) && next_ev && (count_q != '0)) begin
            idx_d = IDX_W'(wrap_next(32'(idx_q), 32'(count_q)));
        end

        if (state_q == ST_LIVE) begin
            disp_d = live_snap;
        end else if (count_q != '0) begin
            disp_d = mem_q[idx_q];
        end
    end

    // Entries beyond lap_count are never shown, so the array needs no reset.
    always_ff @(posedge clk_100Hz) begin
        if (lap_accept) begin
            mem_q[count_q[IDX_W-1:0]] <= live_snap;
        end
    end

    assign disp_hours    = disp_q.hours;
    assign disp_minutes  = disp_q.minutes;
    assign disp_seconds  = disp_q.seconds;
    assign disp_centisec = disp_q.centisec;
    assign lap_count     = count_q;
    assign recall_idx    = idx_q;
    assign full          = full_w;
    assign recall_active = (state_q == ST_RECALL);

endmodule
`default_nettype wire
